// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - instruction/result bundle between ID/EX and alu_exec_unit
interface alu_exec_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  out_valid;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  overflow;
    logic                  busy;

    modport master (
        output in_valid, opcode, funct, shamt, op_a, op_b,
        input  in_ready, out_valid, wr_en, result, zero, overflow, busy
    );

    modport slave (
        input  in_valid, opcode, funct, shamt, op_a, op_b,
        output in_ready, out_valid, wr_en, result, zero, overflow, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - MIPS execute stage with iterative mult/div and HI/LO (option: ALU_OVERFLOW_TRAP_EN)
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam int W = DATA_WIDTH;

`ifdef ALU_OVERFLOW_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_BEQ  = 6'h04, OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a, OP_SLTIU  = 6'h0b, OP_ANDI = 6'h0c, OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f, OP_LW     = 6'h23, OP_SW   = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03, F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11, F_MFLO  = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19, F_DIV  = 6'h1a, F_DIVU = 6'h1b, F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUB   = 6'h22, F_SUBU = 6'h23, F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25, F_XOR   = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state;
    logic                 in_ready_q, busy_q, out_valid_q, wr_en_q, zero_q, overflow_q;
    logic [W-1:0]         result_q, hi_q, lo_q;
    // Shared engine registers: mult uses acc_hi as running upper product and acc_lo as the
    // shifting multiplier; div uses acc_hi as partial remainder and acc_lo as dividend/quotient.
    logic [W-1:0]         acc_hi, acc_lo, mcand, a_raw;
    logic [SHAMT_W-1:0]   cnt;
    logic                 is_div, neg_q, neg_r, div_zero;

    logic [W-1:0] a, b, sum, diff, mag_a, mag_b;
    logic         add_ovf, sub_ovf, lt_s, lt_u, a_pos_nz;
    logic [W-1:0] dec_res;
    logic         dec_wr, dec_ovf, dec_mthi, dec_mtlo, dec_mul, dec_div, dec_signed;
    logic [W:0]   mul_sum, div_shift, div_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0] fix_hi, fix_lo;

    assign a        = bus.op_a;
    assign b        = bus.op_b;
    assign sum      = a + b;
    assign diff     = a - b;
    assign add_ovf  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    assign sub_ovf  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    assign lt_s     = $signed(a) < $signed(b);
    assign lt_u     = a < b;
    assign a_pos_nz = !a[W-1] && (a != '0);
    assign mag_a    = (dec_signed && a[W-1]) ? -a : a;
    assign mag_b    = (dec_signed && b[W-1]) ? -b : b;

    // Opcode/funct decode into a single-cycle result plus control for the iterative engine
    always_comb begin
        dec_res = '0; dec_wr = 1'b0; dec_ovf = 1'b0; dec_mthi = 1'b0; dec_mtlo = 1'b0;
        dec_mul = 1'b0; dec_div = 1'b0; dec_signed = 1'b0;
        case (bus.opcode)
            OP_RTYPE: begin
                case (bus.funct)
                    F_SLL:   begin dec_res = b << bus.shamt;            dec_wr = 1'b1; end
                    F_SRL:   begin dec_res = b >> bus.shamt;            dec_wr = 1'b1; end
                    F_SRA:   begin dec_res = $signed(b) >>> bus.shamt;  dec_wr = 1'b1; end
                    F_MFHI:  begin dec_res = hi_q;                      dec_wr = 1'b1; end
                    F_MFLO:  begin dec_res = lo_q;                      dec_wr = 1'b1; end
                    F_MTHI:  dec_mthi = 1'b1;
                    F_MTLO:  dec_mtlo = 1'b1;
                    F_MULT:  begin dec_mul = 1'b1; dec_signed = 1'b1; end
                    F_MULTU: dec_mul = 1'b1;
                    F_DIV:   begin dec_div = 1'b1; dec_signed = 1'b1; end
                    F_DIVU:  dec_div = 1'b1;
                    F_ADD:   begin dec_res = sum;  dec_wr = 1'b1; dec_ovf = add_ovf; end
                    F_ADDU:  begin dec_res = sum;  dec_wr = 1'b1; end
                    F_SUB:   begin dec_res = diff; dec_wr = 1'b1; dec_ovf = sub_ovf; end
                    F_SUBU:  begin dec_res = diff; dec_wr = 1'b1; end
                    F_AND:   begin dec_res = a & b;    dec_wr = 1'b1; end
                    F_OR:    begin dec_res = a | b;    dec_wr = 1'b1; end
                    F_XOR:   begin dec_res = a ^ b;    dec_wr = 1'b1; end
                    F_NOR:   begin dec_res = ~(a | b); dec_wr = 1'b1; end
                    F_SLT:   begin dec_res = {{(W-1){1'b0}}, lt_s}; dec_wr = 1'b1; end
                    F_SLTU:  begin dec_res = {{(W-1){1'b0}}, lt_u}; dec_wr = 1'b1; end
                    default: ;
                endcase
            end
            OP_REGIMM: dec_res = {{(W-1){1'b0}}, a[W-1]};
            OP_BEQ, OP_BNE: dec_res = diff;
            OP_BLEZ:  dec_res = {{(W-1){1'b0}}, !a_pos_nz};
            OP_BGTZ:  dec_res = {{(W-1){1'b0}}, a_pos_nz};
            OP_ADDI:  begin dec_res = sum; dec_wr = 1'b1; dec_ovf = add_ovf; end
            OP_ADDIU, OP_LW: begin dec_res = sum; dec_wr = 1'b1; end
            OP_SW:    dec_res = sum;
            OP_SLTI:  begin dec_res = {{(W-1){1'b0}}, lt_s}; dec_wr = 1'b1; end
            OP_SLTIU: begin dec_res = {{(W-1){1'b0}}, lt_u}; dec_wr = 1'b1; end
            OP_ANDI:  begin dec_res = a & b; dec_wr = 1'b1; end
            OP_ORI:   begin dec_res = a | b; dec_wr = 1'b1; end
            OP_LUI:   begin dec_res = b << (W/2); dec_wr = 1'b1; end
            default: ;
        endcase
    end

    // One engine step per cycle, and the final sign correction applied in FIX
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift - {1'b0, mcand};
        prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        if (is_div) begin
            fix_lo = div_zero ? '1    : (neg_q ? -acc_lo : acc_lo);
            fix_hi = div_zero ? a_raw : (neg_r ? -acc_hi : acc_hi);
        end else begin
            fix_lo = prod_fix[W-1:0];
            fix_hi = prod_fix[2*W-1:W];
        end
    end

    // Control FSM, engine datapath, HI/LO and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            in_ready_q <= 1'b0; busy_q <= 1'b0; out_valid_q <= 1'b0; wr_en_q <= 1'b0;
            zero_q <= 1'b0; overflow_q <= 1'b0; result_q <= '0; hi_q <= '0; lo_q <= '0;
            acc_hi <= '0; acc_lo <= '0; mcand <= '0; a_raw <= '0; cnt <= '0;
            is_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; div_zero <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        if (dec_mul || dec_div) begin
                            state      <= dec_mul ? S_MUL : S_DIV;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            acc_hi     <= '0;
                            acc_lo     <= dec_mul ? mag_b : mag_a;
                            mcand      <= dec_mul ? mag_a : mag_b;
                            a_raw      <= a;
                            cnt        <= SHAMT_W'(W-1);
                            is_div     <= dec_div;
                            neg_q      <= dec_signed && (a[W-1] ^ b[W-1]);
                            neg_r      <= dec_signed && a[W-1];
                            div_zero   <= dec_div && (b == '0);
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= dec_res;
                            zero_q      <= (dec_res == '0);
                            overflow_q  <= TRAP_EN & dec_ovf;
                            wr_en_q     <= dec_wr & ~(TRAP_EN & dec_ovf);
                            if (dec_mthi) hi_q <= a;
                            if (dec_mtlo) lo_q <= a;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_sum[W:1];
                    acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_DIV: begin
                    if (!div_diff[W]) begin
                        acc_hi <= div_diff[W-1:0];
                        acc_lo <= {acc_lo[W-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[W-1:0];
                        acc_lo <= {acc_lo[W-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                default: begin
                    hi_q        <= fix_hi;
                    lo_q        <= fix_lo;
                    result_q    <= fix_lo;
                    zero_q      <= (fix_lo == '0);
                    overflow_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
endmodule
